// File: rtl/led_pssr_pkg.sv
// Shared types and defaults for the LED panel PSSR sequencer.
//   DEFAULT_WIDTH        : bits per PSSR word (and shift count per word)
//   DEFAULT_LATCH_CYCLES : cycles the panel latch strobe is held high
//   pssr_state_e         : sequencer FSM states
package led_pssr_pkg;

   localparam int unsigned DEFAULT_WIDTH        = 32;
   localparam int unsigned DEFAULT_LATCH_CYCLES = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_A,
      ST_SHIFT_A,
      ST_LOAD_B,
      ST_SHIFT_B,
      ST_LATCH,
      ST_DONE
   } pssr_state_e;

endpackage

// File: rtl/led_pssr_ctrl_if.sv
// Frame-source word-pair handshake.
//   in_valid : source presents a word pair
//   in_ready : sequencer can accept a pair
//   in_a     : word A
//   in_b     : word B
// master = frame source, slave = sequencer.
interface led_pssr_ctrl_if
   import led_pssr_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;

   modport master (output in_valid, output in_a, output in_b, input in_ready);
   modport slave  (input in_valid, input in_a, input in_b, output in_ready);

endinterface

// File: rtl/led_pair_hold.sv
// One-entry pending buffer for A/B word pairs.
//   clk, rst   : clock, async active-high reset
//   in_valid   : source offers a pair
//   in_ready   : buffer empty, pair will be captured
//   in_a, in_b : offered pair
//   drain      : sequencer takes the pending pair this edge
//   pend_valid : buffer holds a pair
//   pend_a/b   : pending pair
module led_pair_hold
   import led_pssr_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             drain,
   output logic             pend_valid,
   output logic [WIDTH-1:0] pend_a,
   output logic [WIDTH-1:0] pend_b
);

   logic capture;

   assign in_ready = ~pend_valid;
   assign capture  = in_valid & in_ready;

   // A capture on a draining edge keeps the entry full with the new pair.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_valid <= 1'b0;
         pend_a     <= '0;
         pend_b     <= '0;
      end else if (capture) begin
         pend_valid <= 1'b1;
         pend_a     <= in_a;
         pend_b     <= in_b;
      end else if (drain) begin
         pend_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/led_pssr_ctrl.sv
// Sequencer for the LED panel parallel-in/serial-out shift register.
// Accepts A/B pairs, loads and shifts A then B through the PSSR, strobes
// the panel latch, enables the panel and pulses frame_done.
//   clk, rst   : clock, async active-high reset
//   src        : word-pair handshake (slave side)
//   pssr_ra/rb : words driven to PSSR rA/rB
//   pssr_load  : PSSR parallel load strobe
//   pssr_sel   : PSSR source select, 0 = A, 1 = B
//   shift_en   : a data bit is valid on the PSSR output
//   latch      : panel latch strobe
//   oe_n       : panel output enable, active low
//   busy       : FSM not idle
//   frame_done : one-cycle pulse at the end of each pair
module led_pssr_ctrl
   import led_pssr_pkg::*;
#(
   parameter int unsigned WIDTH        = DEFAULT_WIDTH,
   parameter int unsigned LATCH_CYCLES = DEFAULT_LATCH_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   led_pssr_ctrl_if.slave   src,
   output logic [WIDTH-1:0] pssr_ra,
   output logic [WIDTH-1:0] pssr_rb,
   output logic             pssr_load,
   output logic             pssr_sel,
   output logic             shift_en,
   output logic             latch,
   output logic             oe_n,
   output logic             busy,
   output logic             frame_done
);

   localparam int unsigned     CNT_W      = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);

   pssr_state_e      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             drain;
   logic             hold_ready;
   logic             pend_valid;
   logic [WIDTH-1:0] pend_a, pend_b;
   logic             load_nxt, sel_nxt, shift_nxt, latch_nxt, oe_n_nxt;

   led_pair_hold #(.WIDTH(WIDTH)) u_hold (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (src.in_valid),
      .in_ready   (hold_ready),
      .in_a       (src.in_a),
      .in_b       (src.in_b),
      .drain      (drain),
      .pend_valid (pend_valid),
      .pend_a     (pend_a),
      .pend_b     (pend_b)
   );

   assign src.in_ready = hold_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next state, counter and next values of the registered outputs.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      unique case (state)
         ST_IDLE:    if (pend_valid) state_nxt = ST_LOAD_A;
         ST_LOAD_A:  state_nxt = ST_SHIFT_A;
         ST_SHIFT_A: if (cnt == SHIFT_LAST) state_nxt = ST_LOAD_B;
         ST_LOAD_B:  state_nxt = ST_SHIFT_B;
         ST_SHIFT_B: if (cnt == SHIFT_LAST) state_nxt = ST_LATCH;
         ST_LATCH:   if (cnt == LATCH_LAST) state_nxt = ST_DONE;
         ST_DONE:    state_nxt = pend_valid ? ST_LOAD_A : ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase

      // Counter clears on every state entry.
      if (state_nxt == state) cnt_nxt = cnt + CNT_W'(1);

      drain = (state_nxt == ST_LOAD_A) && (state != ST_LOAD_A);

      // Outputs are decoded from the next state so they align with it.
      load_nxt  = (state_nxt == ST_LOAD_A) || (state_nxt == ST_LOAD_B);
      shift_nxt = (state_nxt == ST_SHIFT_A) || (state_nxt == ST_SHIFT_B);
      latch_nxt = (state_nxt == ST_LATCH);
      sel_nxt   = pssr_sel;
      if ((state_nxt == ST_LOAD_A) || (state_nxt == ST_SHIFT_A)) sel_nxt = 1'b0;
      if ((state_nxt == ST_LOAD_B) || (state_nxt == ST_SHIFT_B)) sel_nxt = 1'b1;
      // Panel stays dark until the first completed frame, then only during latch.
      oe_n_nxt = oe_n;
      if (state_nxt == ST_LATCH) oe_n_nxt = 1'b1;
      if (state_nxt == ST_DONE)  oe_n_nxt = 1'b0;
   end

   // Counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         pssr_ra    <= '0;
         pssr_rb    <= '0;
         pssr_load  <= 1'b0;
         pssr_sel   <= 1'b0;
         shift_en   <= 1'b0;
         latch      <= 1'b0;
         oe_n       <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         pssr_load  <= load_nxt;
         pssr_sel   <= sel_nxt;
         shift_en   <= shift_nxt;
         latch      <= latch_nxt;
         oe_n       <= oe_n_nxt;
         busy       <= (state_nxt != ST_IDLE);
         frame_done <= (state_nxt == ST_DONE);
         if (drain) begin
            pssr_ra <= pend_a;
            pssr_rb <= pend_b;
         end
      end
   end

endmodule
